// File: rtl/tdp18k_port_arbiter.sv
// Round-robin arbiter sharing TDP18K port A (RAM mode, x18) among NUM_REQ clients.
// Optional power-up clear sweep when TDP18K_ARB_CLEAR_EN is defined.
module tdp18k_port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 3,
  parameter int CLR_WORDS = 1024
) (
  input  logic                 CLK_i,
  input  logic                 RST_ni,
  input  logic [NUM_REQ-1:0]    REQ_i,
  input  logic [NUM_REQ-1:0]    WE_i,
  input  logic [NUM_REQ*10-1:0] ADDR_i,
  input  logic [NUM_REQ*18-1:0] WDATA_i,
  input  logic [NUM_REQ*2-1:0]  BE_i,
  output logic [NUM_REQ-1:0]    GNT_o,
  output logic                 BUSY_o,
  output logic                 RVALID_o,
  output logic [ID_W-1:0]      RID_o,
  output logic [17:0]          RDATA_o,
  output logic                 WEN_A_o,
  output logic                 REN_A_o,
  output logic [1:0]           BE_A_o,
  output logic [13:0]          ADDR_A_o,
  output logic [17:0]          WDATA_A_o,
  output logic [2:0]           WMODE_A_o,
  output logic [2:0]           RMODE_A_o,
  input  logic [17:0]          RDATA_A_i
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_win;
  logic            w_found;
  logic            w_grant;
  logic            w_clr;
  logic            w_busy;
  logic [9:0]      w_clr_addr;
  logic            w_we;
  logic [9:0]      w_addr;
  logic [17:0]     w_wdata;
  logic [1:0]      w_be;
  logic            r_v1;
  logic [ID_W-1:0] r_id1;

`ifdef TDP18K_ARB_CLEAR_EN
  typedef enum logic {S_CLEAR, S_ARB} state_t;
  state_t     r_state;
  state_t     w_state_nxt;
  logic [9:0] r_cnt;

  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CLEAR) r_cnt <= r_cnt + 10'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    if (r_state == S_CLEAR) begin
      w_clr = 1'b1;
      if (r_cnt == 10'(CLR_WORDS-1)) w_state_nxt = S_ARB;
    end
  end

  assign w_clr_addr = r_cnt;
  assign w_busy     = w_clr & RST_ni;
`else
  assign w_clr      = 1'b0;
  assign w_clr_addr = '0;
  assign w_busy     = 1'b0;
`endif

  // scan ptr, ptr+1, ... wrapping at NUM_REQ; first requester wins
  always_comb begin
    logic [ID_W:0] v;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (v >= (ID_W+1)'(NUM_REQ)) v = v - (ID_W+1)'(NUM_REQ);
      for (int n = 0; n < NUM_REQ; n++) begin
        if (!w_found && REQ_i[n] && v[ID_W-1:0] == ID_W'(n)) begin
          w_found = 1'b1;
          w_win   = ID_W'(n);
        end
      end
    end
  end

  always_comb begin
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    w_be    = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (w_win == ID_W'(n)) begin
        w_we    = WE_i[n];
        w_addr  = ADDR_i[n*10 +: 10];
        w_wdata = WDATA_i[n*18 +: 18];
        w_be    = BE_i[n*2 +: 2];
      end
    end
  end

  assign w_grant = w_found & RST_ni & ~w_clr;

  always_comb begin
    GNT_o = '0;
    if (w_grant) GNT_o[w_win] = 1'b1;
  end

  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      if (w_win == ID_W'(NUM_REQ-1)) r_ptr <= '0;
      else                          r_ptr <= w_win + ID_W'(1);
    end
  end

  // ADDR/WDATA/BE hold their last values when the port idles
  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      WEN_A_o   <= 1'b0;
      REN_A_o   <= 1'b0;
      BE_A_o    <= '0;
      ADDR_A_o  <= '0;
      WDATA_A_o <= '0;
    end else if (w_clr) begin
      WEN_A_o   <= 1'b1;
      REN_A_o   <= 1'b0;
      BE_A_o    <= 2'b11;
      ADDR_A_o  <= {w_clr_addr, 4'b0000};
      WDATA_A_o <= '0;
    end else if (w_grant) begin
      ADDR_A_o <= {w_addr, 4'b0000};
      if (w_we) begin
        WEN_A_o   <= 1'b1;
        REN_A_o   <= 1'b0;
        BE_A_o    <= w_be;
        WDATA_A_o <= w_wdata;
      end else begin
        WEN_A_o   <= 1'b0;
        REN_A_o   <= 1'b1;
        BE_A_o    <= '0;
        WDATA_A_o <= '0;
      end
    end else begin
      WEN_A_o <= 1'b0;
      REN_A_o <= 1'b0;
    end
  end

  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      r_v1     <= 1'b0;
      r_id1    <= '0;
      RVALID_o <= 1'b0;
      RID_o    <= '0;
    end else begin
      r_v1     <= w_grant & ~w_we;
      r_id1    <= w_win;
      RVALID_o <= r_v1;
      RID_o    <= r_id1;
    end
  end

  assign RDATA_o   = RDATA_A_i;
  assign BUSY_o    = w_busy;
  assign WMODE_A_o = 3'b010;
  assign RMODE_A_o = 3'b010;

endmodule

// File: doc/tdp18k_port_arbiter.md
Name: tdp18k_port_arbiter

Overview:
- Shares port A of one TDP18K_FIFO instance, used in RAM mode (FMODE_i=0), between NUM_REQ requesters.
- Round-robin arbitration with one-hot grant; registered RAM command stage; read data returned tagged with the requester ID.
- Sits between client logic and the BRAM primitive. The arbiter is the only driver of the port-A RAM inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 3, width of the returned requester ID (≥ clog2(NUM_REQ)).
- CLR_WORDS, 1024, number of x18 words swept by the clear engine (optional feature only).

Ports:
- CLK_i  in  1  single clock; also drives CLK_A_i of the RAM.
- RST_ni  in  1  asynchronous active-low reset.
- REQ_i  in  NUM_REQ  per-requester request; held until granted.
- WE_i  in  NUM_REQ  1=write, 0=read, per requester.
- ADDR_i  in  NUM_REQ*10  word address, x18 granularity; slice n is [10n+9:10n].
- WDATA_i  in  NUM_REQ*18  write data; slice n is [18n+17:18n].
- BE_i  in  NUM_REQ*2  byte enables for writes.
- GNT_o  out  NUM_REQ  one-hot grant, combinational, in the accept cycle.
- BUSY_o  out  1  high while no grant is possible (clear engine active).
- RVALID_o  out  1  read data valid.
- RID_o  out  ID_W  requester index of the returning read.
- RDATA_o  out  18  read data.
- WEN_A_o, REN_A_o  out  1 each  RAM port-A write/read enables.
- BE_A_o  out  2  RAM byte enables.
- ADDR_A_o  out  14  RAM address = {word_addr,4'b0000}.
- WDATA_A_o  out  18  RAM write data.
- WMODE_A_o, RMODE_A_o  out  3 each  constant 3'b010 (MODE_18).
- RDATA_A_i  in  18  RAM port-A read data.

Behaviour:
- Reset (async, RST_ni=0) sets:
  - GNT_o=0, RVALID_o=0, RID_o=0.
  - WEN_A_o=0, REN_A_o=0, BE_A_o=0, ADDR_A_o=0, WDATA_A_o=0.
  - RR pointer=0, BUSY_o=0.
- Release from reset is synchronous to CLK_i.
- Arbitration, cycle t:
  - Winner w = first n with REQ_i[n]=1, scanning ptr, ptr+1, … mod NUM_REQ.
  - GNT_o[w]=1 combinationally in t; no grant if BUSY_o=1 or no request.
  - At the edge ending t: ptr <= (w+1) mod NUM_REQ. ptr holds when no grant.
  - One grant per cycle maximum, so back-to-back grants are allowed (throughput 1/cycle).
- Command stage, cycle t+1 (registered):
  - Write (WE_i[w]=1): WEN_A_o=1, REN_A_o=0, BE_A_o=BE_i slice, WDATA_A_o=WDATA_i slice.
  - Read (WE_i[w]=0): WEN_A_o=0, REN_A_o=1, BE_A_o=0, WDATA_A_o=0.
  - ADDR_A_o={ADDR_i slice, 4'b0} in both cases.
  - No grant in t: WEN_A_o=REN_A_o=0, and ADDR/WDATA hold their previous values.
- Read return, cycle t+2:
  - RVALID_o=1, RID_o=w, RDATA_o=RDATA_A_i (RAM registered-read latency is 1 cycle).
  - A 2-stage valid/ID pipeline tracks in-flight reads. RDATA_o may be ignored when RVALID_o=0.
  - Reads have fixed latency, so requesters need no ready signal and there is no backpressure.
- Write-then-read to the same address in consecutive grants returns the new data (RAM write completes before the next command).
- Requester dropping REQ_i before grant: no effect, no grant issued to it.
- REQ_i asserted only in the same cycle as an other's grant: waits its turn; maximum wait is NUM_REQ-1 grants.
- Reset mid-operation: in-flight reads are discarded (no RVALID_o after reset); RAM contents are not touched.

Optional Feature:
- Macro TDP18K_ARB_CLEAR_EN.
- Defined:
  - After reset deassert, FSM states go CLEAR → ARB.
  - In CLEAR: BUSY_o=1, GNT_o=0. Each cycle the block writes 18'h0 with BE_A_o=2'b11 to addresses 0..CLR_WORDS-1 via a 10-bit counter, one word per cycle.
  - On the last word, transition to ARB; BUSY_o falls the cycle after the final write is issued.
  - Total CLEAR duration is CLR_WORDS cycles.
  - RVALID_o stays 0 throughout CLEAR.
- Undefined: FSM starts in ARB, BUSY_o is tied 0, and no counter is synthesized.

Test Plan:
- Reset with all REQ_i=4'b1111 held, no clear → GNT_o sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles; WEN_A_o/REN_A_o pulse in each cycle one later.
- Req 2 writes addr 10'h155, data 18'h2ABCD, BE=11; then req 0 reads 10'h155 → ADDR_A_o=14'h1550 on both commands; RVALID_o=1, RID_o=0, RDATA_o=18'h2ABCD exactly 2 cycles after the read grant.
- Write with BE=2'b01 data 18'h3FFFF over 18'h00000, then read → 18'h100FF.
- Only req 3 requesting, continuously → GNT_o=1000 every cycle; ptr wraps to 0 each time; no starvation once req 1 joins (grant within ≤2 cycles).
- Assert RST_ni=0 one cycle after a read grant → RVALID_o never asserts; all outputs 0 during reset.
- With TDP18K_ARB_CLEAR_EN, CLR_WORDS=1024 → BUSY_o=1 for 1024 cycles, ADDR_A_o walks 14'h0000..14'h3FF0; a later read of any address returns 18'h0; REQ_i held during CLEAR gets its first grant only after BUSY_o=0.
